// File: rtl/mem_dp_if.sv
// -----------------------------------------------------------------------------
// mem_dp_if
//   Bundle of the two request/response ports of the mem_dp dual-port RAM.
//   Signal names keep the mem_<field>_<port> naming used across the LSTM
//   datapath, so existing netlists and probes still match.
//
//   master modport : request side (drives enables, address, write data;
//                    receives read data and valid)
//   slave modport  : the RAM itself
//
//   Per port x in {a, b}:
//     mem_we_x     write enable
//     mem_re_x     read enable
//     mem_addr_x   word address (AWIDTH bits)
//     mem_wdata_x  write data   (DWIDTH bits)
//     mem_rdata_x  registered read data
//     mem_rvalid_x read data valid, one cycle per accepted read
// -----------------------------------------------------------------------------
interface mem_dp_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 10
);
  logic              mem_we_a;
  logic              mem_re_a;
  logic [AWIDTH-1:0] mem_addr_a;
  logic [DWIDTH-1:0] mem_wdata_a;
  logic [DWIDTH-1:0] mem_rdata_a;
  logic              mem_rvalid_a;

  logic              mem_we_b;
  logic              mem_re_b;
  logic [AWIDTH-1:0] mem_addr_b;
  logic [DWIDTH-1:0] mem_wdata_b;
  logic [DWIDTH-1:0] mem_rdata_b;
  logic              mem_rvalid_b;

  modport master (
    output mem_we_a, mem_re_a, mem_addr_a, mem_wdata_a,
    input  mem_rdata_a, mem_rvalid_a,
    output mem_we_b, mem_re_b, mem_addr_b, mem_wdata_b,
    input  mem_rdata_b, mem_rvalid_b
  );

  modport slave (
    input  mem_we_a, mem_re_a, mem_addr_a, mem_wdata_a,
    output mem_rdata_a, mem_rvalid_a,
    input  mem_we_b, mem_re_b, mem_addr_b, mem_wdata_b,
    output mem_rdata_b, mem_rvalid_b
  );
endinterface

// File: rtl/mem_dp.sv
// -----------------------------------------------------------------------------
// mem_dp
//   True dual-port synchronous RAM, shared weight/state buffer of the LSTM
//   datapath. Each port does one read and/or one write per cycle.
//
//   Behaviour:
//     - read-first: a read always returns the contents before this edge's
//       writes, on the same port and across ports
//     - write/write collision on one address: port A wins
//     - addresses >= WORDS: writes dropped, reads return zero with valid
//     - rdata holds when no read is issued; rvalid pulses once per read
//
//   Ports:
//     clk   clock, rising edge
//     xrst  asynchronous active-low reset, clears output registers only
//     bus   mem_dp_if.slave, ports A and B
//
//   Parameters:
//     DWIDTH  data width
//     WORDS   number of words (>= 2, any value)
//     AWIDTH  address width, defaults to $clog2(WORDS)
//
//   Build option:
//     MEM_DP_OUTREG_EN  adds a second output register stage on rdata/rvalid
//                       of both ports (read latency 2 instead of 1)
// -----------------------------------------------------------------------------
module mem_dp #(
  parameter int DWIDTH = 16,
  parameter int WORDS  = 1024,
  parameter int AWIDTH = $clog2(WORDS)
) (
  input  logic        clk,
  input  logic        xrst,
  mem_dp_if.slave     bus
);

  // Compared one bit wider so a power-of-two WORDS still fits the constant.
  localparam logic [AWIDTH:0] WORDS_LIM = WORDS[AWIDTH:0];

  // NOTE: the storage array has no reset; clearing it would turn the RAM into
  // a large flop bank and its contents are undefined until written anyway.
  logic [DWIDTH-1:0] mem [WORDS];

  logic in_range_a;
  logic in_range_b;
  logic wr_en_a;
  logic wr_en_b;
  logic rd_en_a;
  logic rd_en_b;

  assign in_range_a = {1'b0, bus.mem_addr_a} < WORDS_LIM;
  assign in_range_b = {1'b0, bus.mem_addr_b} < WORDS_LIM;

  // Requests are ignored while reset is held. Port B's write is dropped when
  // port A writes the same word in the same cycle.
  assign wr_en_a = xrst & bus.mem_we_a & in_range_a;
  assign wr_en_b = xrst & bus.mem_we_b & in_range_b &
                   ~(wr_en_a && (bus.mem_addr_a == bus.mem_addr_b));
  assign rd_en_a = bus.mem_re_a;
  assign rd_en_b = bus.mem_re_b;

  always_ff @(posedge clk) begin
    if (wr_en_a) mem[bus.mem_addr_a] <= bus.mem_wdata_a;
    if (wr_en_b) mem[bus.mem_addr_b] <= bus.mem_wdata_b;
  end

  // First output stage. NOTE: non-blocking assignment here means the read
  // samples mem before this edge's writes land, which is exactly read-first.
  logic [DWIDTH-1:0] rdata_a_q;
  logic [DWIDTH-1:0] rdata_b_q;
  logic              rvalid_a_q;
  logic              rvalid_b_q;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      rvalid_a_q <= rd_en_a;
      rvalid_b_q <= rd_en_b;
      if (rd_en_a) rdata_a_q <= in_range_a ? mem[bus.mem_addr_a] : '0;
      if (rd_en_b) rdata_b_q <= in_range_b ? mem[bus.mem_addr_b] : '0;
    end
  end

`ifdef MEM_DP_OUTREG_EN
  // Second output stage: rdata only loads when the first stage delivers a
  // word, so it holds between reads exactly like the single-stage build.
  logic [DWIDTH-1:0] rdata_a_q2;
  logic [DWIDTH-1:0] rdata_b_q2;
  logic              rvalid_a_q2;
  logic              rvalid_b_q2;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      rdata_a_q2  <= '0;
      rdata_b_q2  <= '0;
      rvalid_a_q2 <= 1'b0;
      rvalid_b_q2 <= 1'b0;
    end else begin
      rvalid_a_q2 <= rvalid_a_q;
      rvalid_b_q2 <= rvalid_b_q;
      if (rvalid_a_q) rdata_a_q2 <= rdata_a_q;
      if (rvalid_b_q) rdata_b_q2 <= rdata_b_q;
    end
  end

  assign bus.mem_rdata_a  = rdata_a_q2;
  assign bus.mem_rdata_b  = rdata_b_q2;
  assign bus.mem_rvalid_a = rvalid_a_q2;
  assign bus.mem_rvalid_b = rvalid_b_q2;
`else
  assign bus.mem_rdata_a  = rdata_a_q;
  assign bus.mem_rdata_b  = rdata_b_q;
  assign bus.mem_rvalid_a = rvalid_a_q;
  assign bus.mem_rvalid_b = rvalid_b_q;
`endif

endmodule

// File: tb/tb_mem_dp.sv
// -----------------------------------------------------------------------------
// tb_mem_dp
//   Directed self-checking bench for mem_dp (DWIDTH=16, WORDS=1000).
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, half a cycle away from the rising edge the RAM uses.
// -----------------------------------------------------------------------------
module tb_mem_dp;

  localparam int DWIDTH = 16;
  localparam int WORDS  = 1000;
  localparam int AWIDTH = 10;
`ifdef MEM_DP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic xrst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mem_dp_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) bus ();

  mem_dp #(.DWIDTH(DWIDTH), .WORDS(WORDS), .AWIDTH(AWIDTH)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.mem_we_a = 1'b0; bus.mem_re_a = 1'b0; bus.mem_addr_a = '0; bus.mem_wdata_a = '0;
    bus.mem_we_b = 1'b0; bus.mem_re_b = 1'b0; bus.mem_addr_b = '0; bus.mem_wdata_b = '0;
  endtask

  // Drive one cycle of requests on both ports, then step to the next falling edge.
  task automatic op(input logic we_a, input logic re_a, input logic [AWIDTH-1:0] addr_a,
                    input logic [DWIDTH-1:0] wdata_a,
                    input logic we_b, input logic re_b, input logic [AWIDTH-1:0] addr_b,
                    input logic [DWIDTH-1:0] wdata_b);
    bus.mem_we_a = we_a; bus.mem_re_a = re_a; bus.mem_addr_a = addr_a; bus.mem_wdata_a = wdata_a;
    bus.mem_we_b = we_b; bus.mem_re_b = re_b; bus.mem_addr_b = addr_b; bus.mem_wdata_b = wdata_b;
    @(negedge clk);
    idle();
  endtask

  // After a read cycle, wait for the remaining pipeline stages.
  task automatic wait_out();
    for (int i = 1; i < LAT; i++) @(negedge clk);
  endtask

  initial begin
    idle();

    // Reset held with live requests: outputs stay cleared, nothing is accepted.
    bus.mem_we_a = 1'b1; bus.mem_re_a = 1'b1; bus.mem_addr_a = 10'd5; bus.mem_wdata_a = 16'hDEAD;
    bus.mem_re_b = 1'b1; bus.mem_addr_b = 10'd5;
    repeat (3) @(negedge clk);
    check("rst_rdata_a",  32'(bus.mem_rdata_a),  32'h0);
    check("rst_rvalid_a", 32'(bus.mem_rvalid_a), 32'h0);
    check("rst_rdata_b",  32'(bus.mem_rdata_b),  32'h0);
    check("rst_rvalid_b", 32'(bus.mem_rvalid_b), 32'h0);
    idle();
    xrst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_rvalid_a", 32'(bus.mem_rvalid_a), 32'h0);
    check("post_rst_rdata_b",  32'(bus.mem_rdata_b),  32'h0);

    // Basic write on A, read on B the next cycle.
    op(1, 0, 10'd5, 16'h1234, 0, 0, 10'd0, 16'h0);
    op(0, 0, 10'd0, 16'h0,    0, 1, 10'd5, 16'h0);
    wait_out();
    check("basic_rdata_b",  32'(bus.mem_rdata_b),  32'h1234);
    check("basic_rvalid_b", 32'(bus.mem_rvalid_b), 32'h1);
    check("basic_rvalid_a", 32'(bus.mem_rvalid_a), 32'h0);

    // Read-first on the writing port and across ports.
    op(1, 0, 10'd7, 16'h00AA, 0, 0, 10'd0, 16'h0);
    op(1, 1, 10'd7, 16'h00BB, 0, 1, 10'd7, 16'h0);
    wait_out();
    check("rf_rdata_a",  32'(bus.mem_rdata_a),  32'h00AA);
    check("rf_rvalid_a", 32'(bus.mem_rvalid_a), 32'h1);
    check("rf_rdata_b",  32'(bus.mem_rdata_b),  32'h00AA);
    check("rf_rvalid_b", 32'(bus.mem_rvalid_b), 32'h1);
    op(0, 1, 10'd7, 16'h0, 0, 0, 10'd0, 16'h0);
    wait_out();
    check("rf_new_rdata_a", 32'(bus.mem_rdata_a), 32'h00BB);

    // Write/write collision: port A wins.
    op(1, 0, 10'd3, 16'h1111, 1, 0, 10'd3, 16'h2222);
    op(0, 0, 10'd0, 16'h0,    0, 1, 10'd3, 16'h0);
    wait_out();
    check("wwc_rdata_b", 32'(bus.mem_rdata_b), 32'h1111);

    // Out of range: write dropped, read returns zero with valid.
    op(1, 0, 10'd1000, 16'hFFFF, 1, 0, 10'd999, 16'h0042);
    op(0, 1, 10'd1000, 16'h0,    0, 1, 10'd999, 16'h0);
    wait_out();
    check("oor_rdata_a",  32'(bus.mem_rdata_a),  32'h0);
    check("oor_rvalid_a", 32'(bus.mem_rvalid_a), 32'h1);
    check("last_rdata_b", 32'(bus.mem_rdata_b),  32'h0042);
    op(0, 1, 10'd999, 16'h0, 0, 1, 10'd5, 16'h0);
    wait_out();
    check("last_rdata_a",  32'(bus.mem_rdata_a), 32'h0042);
    check("intact_rdata_b", 32'(bus.mem_rdata_b), 32'h1234);

    // Streaming: fill 0..15, then read them back-to-back on A.
    for (int i = 0; i < 16; i++) op(1, 0, AWIDTH'(i), 16'hA000 + 16'(i), 0, 0, 10'd0, 16'h0);
    for (int i = 0; i < 16 + LAT; i++) begin
      if (i >= LAT) begin
        check($sformatf("stream_rvalid_%0d", i - LAT), 32'(bus.mem_rvalid_a), 32'h1);
        check($sformatf("stream_rdata_%0d", i - LAT), 32'(bus.mem_rdata_a), 32'hA000 + 32'(i - LAT));
      end
      bus.mem_re_a   = (i < 16);
      bus.mem_addr_a = AWIDTH'(i < 16 ? i : 0);
      @(negedge clk);
    end
    idle();
    check("hold_rvalid_a", 32'(bus.mem_rvalid_a), 32'h0);
    check("hold_rdata_a",  32'(bus.mem_rdata_a),  32'hA00F);
    @(negedge clk);
    check("hold2_rdata_a", 32'(bus.mem_rdata_a),  32'hA00F);

    // Reset asserted while a read is in flight: nothing is delivered afterwards.
    bus.mem_re_a = 1'b1; bus.mem_addr_a = 10'd5;
    @(posedge clk);
    #1;
    xrst = 1'b0;
    idle();
    #2;
    check("midrst_rvalid_a", 32'(bus.mem_rvalid_a), 32'h0);
    check("midrst_rdata_a",  32'(bus.mem_rdata_a),  32'h0);
    @(negedge clk);
    xrst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("after_midrst_rvalid_a", 32'(bus.mem_rvalid_a), 32'h0);
    end
    check("after_midrst_rdata_a", 32'(bus.mem_rdata_a), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
